// File: rtl/pkt_router_n_if.sv
// Byte-stream input, per-channel read handshake and packet status for pkt_router_n.
// The router connects through the slave modport; the upstream deserialiser and the
// downstream consumers drive through the master modport.
interface pkt_router_n_if #(
  parameter int DW    = 8,
  parameter int NCH   = 3,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic [NCH-1:0]         out_valid;
  logic [NCH-1:0]         out_ready;
  logic [NCH*DW-1:0]      out_data;
  logic [NCH*(AW+1)-1:0]  out_count;
  logic                   busy;
  logic                   pkt_ok;
  logic                   pkt_err;
  logic                   pkt_drop;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_count, busy, pkt_ok, pkt_err, pkt_drop
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_count, busy, pkt_ok, pkt_err, pkt_drop
  );
endinterface

// File: rtl/pkt_router_n.sv
// Framed-packet router: header / payload / parity bytes on one stream, payload
// steered into one of NCH first-word-fall-through FIFOs. Payload is written
// speculatively and only becomes visible to the reader when parity checks out;
// a bad parity rolls the speculative write pointer back. Packets that would not
// fit, or that name a nonexistent channel, are consumed and reported as dropped.
module pkt_router_n #(
  parameter int DW    = 8,
  parameter int NCH   = 3,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pkt_router_n_if.slave bus
);
  localparam int CHW  = (NCH <= 2) ? 1 : $clog2(NCH);
  localparam int LENW = DW - CHW;
  localparam int AW   = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} state_t;

  state_t state, state_n;

  // Packet context captured from the header
  logic [CHW-1:0]  ch_r;
  logic [LENW-1:0] len_r;
  logic [LENW-1:0] cnt_r;
  logic [DW-1:0]   acc;
  logic            drop_r;

  // Per-channel FIFO state
  logic [DW-1:0] mem   [NCH][DEPTH];
  logic [AW-1:0] wc    [NCH];
  logic [AW-1:0] ws    [NCH];
  logic [AW-1:0] rp    [NCH];
  logic [AW:0]   count [NCH];

  // FSM strobes
  logic hdr_acc, pay_acc, wr_en, commit, rollback, drop_end;
  logic [NCH-1:0] pop;

  // Header field views and occupancy of the addressed channel
  logic [CHW-1:0]  hdr_ch;
  logic [LENW-1:0] hdr_len;
  logic [AW:0]     hdr_occ;

  logic pkt_ok_p1, pkt_err_p1, pkt_drop_p1;

  // A packet is refused when its channel does not exist or its payload exceeds free space
  function automatic logic drop_check(input logic [CHW-1:0] ch,
                                      input logic [LENW-1:0] len,
                                      input logic [AW:0] occ);
    drop_check = (32'(ch) >= 32'(NCH)) || (32'(len) > (32'(DEPTH) - 32'(occ)));
  endfunction

  assign hdr_ch  = bus.in_data[CHW-1:0];
  assign hdr_len = bus.in_data[DW-1:CHW];

  // Occupancy lookup guarded against out-of-range channel numbers
  always_comb begin
    hdr_occ = '0;
    if (32'(hdr_ch) < 32'(NCH)) hdr_occ = count[hdr_ch];
  end

  // Input FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-byte strobes; only valid bytes advance the FSM
  always_comb begin
    state_n  = state;
    hdr_acc  = 1'b0;
    pay_acc  = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    drop_end = 1'b0;
    if (bus.in_valid) begin
      case (state)
        IDLE: begin
          hdr_acc = 1'b1;
          state_n = (hdr_len != '0) ? PAYLOAD : PARITY;
        end
        PAYLOAD: begin
          pay_acc = 1'b1;
          wr_en   = !drop_r;
          if (cnt_r + LENW'(1) == len_r) state_n = PARITY;
        end
        PARITY: begin
          state_n = IDLE;
          if (drop_r)                 drop_end = 1'b1;
          else if (acc == bus.in_data) commit  = 1'b1;
          else                         rollback = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Packet context: header capture, payload count and running parity
  always_ff @(posedge clk) begin
    if (hdr_acc) begin
      ch_r   <= hdr_ch;
      len_r  <= hdr_len;
      cnt_r  <= '0;
      acc    <= bus.in_data;
      drop_r <= drop_check(hdr_ch, hdr_len, hdr_occ);
    end else if (pay_acc) begin
      cnt_r <= cnt_r + LENW'(1);
      acc   <= acc ^ bus.in_data;
    end
  end

  // Payload storage, written at the speculative pointer of the packet's channel
  always_ff @(posedge clk) begin
    if (wr_en) mem[ch_r][ws[ch_r]] <= bus.in_data;
  end

  // Pops are honoured only on channels holding committed data
  always_comb begin
    pop = '0;
    for (int c = 0; c < NCH; c++) pop[c] = bus.out_ready[c] && (count[c] != '0);
  end

  // Pointer and occupancy bookkeeping: speculative write, commit, rollback, pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        wc[c]    <= '0;
        ws[c]    <= '0;
        rp[c]    <= '0;
        count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && ch_r == CHW'(c))         ws[c] <= ws[c] + AW'(1);
        else if (rollback && ch_r == CHW'(c)) ws[c] <= wc[c];
        if (commit && ch_r == CHW'(c))        wc[c] <= ws[c];
        if (pop[c])                           rp[c] <= rp[c] + AW'(1);
        count[c] <= count[c]
                    + ((commit && ch_r == CHW'(c)) ? (AW+1)'(len_r) : '0)
                    - (pop[c] ? (AW+1)'(1) : '0);
      end
    end
  end

  // ---- status stage: end-of-packet pulses one cycle after the parity byte ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_ok_p1   <= 1'b0;
      pkt_err_p1  <= 1'b0;
      pkt_drop_p1 <= 1'b0;
    end else begin
      pkt_ok_p1   <= commit;
      pkt_err_p1  <= rollback;
      pkt_drop_p1 <= drop_end;
    end
  end

  assign bus.pkt_ok   = pkt_ok_p1;
  assign bus.pkt_err  = pkt_err_p1;
  assign bus.pkt_drop = pkt_drop_p1;
  assign bus.busy     = (state != IDLE);

  // Fall-through read view: head byte and committed occupancy per channel
  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    bus.out_count = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.out_valid[c]                  = (count[c] != '0);
      bus.out_count[c*(AW+1) +: (AW+1)] = count[c];
      if (count[c] != '0) bus.out_data[c*DW +: DW] = mem[c][rp[c]];
    end
  end
endmodule

// File: tb/tb_pkt_router_n.sv
// Bench for pkt_router_n: a vector table for the basic packet flows, hand-built
// sequences for full/wrap, pop-during-commit and mid-packet reset, then random
// traffic, all checked every cycle against a packet-level queue model.
module tb_pkt_router_n;
  localparam int DW    = 8;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_router_n_if #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) bus ();

  pkt_router_n #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed bytes per channel and the packet being received
  logic [7:0] mq [NCH][$];
  logic [7:0] pbuf [$];
  int         m_ch, m_len;
  logic       m_drop;
  logic       e_ok, e_err, e_drop;

  logic [7:0] pay [$];
  logic       rand_rdy = 1'b0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] rdy;
    logic [3:0] flags;   // {busy, pkt_ok, pkt_err, pkt_drop}
    logic [2:0] valid;
    logic [23:0] data;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic [NCH-1:0] rdy);
    logic [7:0] add [$];
    logic [7:0] x;
    add.delete();
    e_ok = 1'b0; e_err = 1'b0; e_drop = 1'b0;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      pbuf.delete();
      return;
    end
    if (v) begin
      pbuf.push_back(d);
      if (pbuf.size() == 1) begin
        m_ch  = int'(d) % 4;
        m_len = int'(d) / 4;
        if (m_ch >= NCH) m_drop = 1'b1;
        else             m_drop = (m_len > DEPTH - int'(mq[m_ch].size()));
      end
      if (int'(pbuf.size()) == m_len + 2) begin
        x = 8'h00;
        for (int i = 0; i < m_len + 1; i++) x ^= pbuf[i];
        if (m_drop) e_drop = 1'b1;
        else if (x == pbuf[m_len + 1]) begin
          e_ok = 1'b1;
          for (int i = 1; i <= m_len; i++) add.push_back(pbuf[i]);
        end else e_err = 1'b1;
        pbuf.delete();
      end
    end
    for (int c = 0; c < NCH; c++)
      if (rdy[c] && mq[c].size() > 0) void'(mq[c].pop_front());
    foreach (add[i]) mq[m_ch].push_back(add[i]);
  endtask

  task automatic model_check();
    chk("busy", 32'(bus.busy), 32'(pbuf.size() != 0));
    chk("pkt_ok", 32'(bus.pkt_ok), 32'(e_ok));
    chk("pkt_err", 32'(bus.pkt_err), 32'(e_err));
    chk("pkt_drop", 32'(bus.pkt_drop), 32'(e_drop));
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("valid%0d", c), 32'(bus.out_valid[c]), 32'(mq[c].size() != 0));
      chk($sformatf("count%0d", c), 32'(bus.out_count[c*(AW+1) +: (AW+1)]), 32'(mq[c].size()));
      chk($sformatf("data%0d", c), 32'(bus.out_data[c*DW +: DW]),
          (mq[c].size() != 0) ? 32'(mq[c][0]) : 32'h0);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [NCH-1:0] rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(v, d, rdy);
    #1;
    model_check();
  endtask

  function automatic logic [NCH-1:0] rr();
    if (!rand_rdy) return '0;
    return NCH'($urandom_range(0, 7)) & NCH'($urandom_range(0, 7));
  endfunction

  task automatic drive_byte(input logic [7:0] b, input int gap_pct, input logic [NCH-1:0] rdy_here);
    while (int'($urandom_range(0, 99)) < gap_pct) cycle(1'b0, 8'h00, rr());
    cycle(1'b1, b, rand_rdy ? rr() : rdy_here);
  endtask

  // Header, payload from 'pay', parity (corrupted when bad); rdy_par applies on the parity byte
  task automatic send_pkt(input logic [7:0] hdr, input logic bad, input int gap_pct,
                          input logic [NCH-1:0] rdy_par);
    logic [7:0] par;
    par = hdr;
    foreach (pay[i]) par ^= pay[i];
    if (bad) par ^= 8'($urandom_range(1, 255));
    drive_byte(hdr, gap_pct, '0);
    foreach (pay[i]) drive_byte(pay[i], gap_pct, '0);
    drive_byte(par, gap_pct, rdy_par);
  endtask

  task automatic addv(input logic v, input logic [7:0] d, input logic [2:0] rdy,
                      input logic [3:0] flags, input logic [2:0] valid, input logic [23:0] data);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.flags = flags; t.valid = valid; t.data = data;
    tbl.push_back(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_b;
    int ch, len;
    logic [7:0] hdr;

    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = '0;

    // good packet / pops / bad parity / rollback / invalid channel
    addv(1, 8'h0D, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h11, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h22, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h33, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h0D, 3'b000, 4'b0100, 3'b010, 24'h001100);
    addv(0, 8'h00, 3'b010, 4'b0000, 3'b010, 24'h002200);
    addv(0, 8'h00, 3'b010, 4'b0000, 3'b010, 24'h003300);
    addv(0, 8'h00, 3'b010, 4'b0000, 3'b000, 24'h000000);
    addv(0, 8'h00, 3'b010, 4'b0000, 3'b000, 24'h000000);
    addv(1, 8'h0D, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h11, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h22, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h33, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h0C, 3'b000, 4'b0010, 3'b000, 24'h000000);
    addv(1, 8'h05, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(0, 8'h00, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h5A, 3'b000, 4'b1000, 3'b000, 24'h000000);
    addv(1, 8'h5F, 3'b000, 4'b0100, 3'b010, 24'h005A00);
    addv(1, 8'h07, 3'b000, 4'b1000, 3'b010, 24'h005A00);
    addv(1, 8'hAA, 3'b000, 4'b1000, 3'b010, 24'h005A00);
    addv(1, 8'hAD, 3'b000, 4'b0001, 3'b010, 24'h005A00);
    addv(0, 8'h00, 3'b010, 4'b0000, 3'b000, 24'h000000);

    // reset state
    rst_n = 1'b0;
    repeat (3) cycle(1'b0, 8'h00, '0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_count", 32'(bus.out_count), 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, '0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("t%0d_flags", i), 32'({bus.busy, bus.pkt_ok, bus.pkt_err, bus.pkt_drop}),
          32'(tbl[i].flags));
      chk($sformatf("t%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].valid));
      chk($sformatf("t%0d_data", i), 32'(bus.out_data), 32'(tbl[i].data));
    end

    // full channel and pointer wrap on ch0
    pay.delete();
    for (int i = 1; i <= 16; i++) pay.push_back(8'(i));
    send_pkt(8'h40, 1'b0, 0, '0);
    chk("full_ok", 32'(bus.pkt_ok), 32'h1);
    chk("full_count", 32'(bus.out_count[4:0]), 32'd16);
    pay.delete(); pay.push_back(8'h77);
    send_pkt(8'h04, 1'b0, 0, '0);
    chk("full_drop", 32'(bus.pkt_drop), 32'h1);
    chk("full_noerr", 32'(bus.pkt_err), 32'h0);
    chk("full_count2", 32'(bus.out_count[4:0]), 32'd16);
    cycle(1'b0, 8'h00, 3'b001);
    send_pkt(8'h04, 1'b0, 0, '0);
    chk("wrap_ok", 32'(bus.pkt_ok), 32'h1);
    chk("wrap_count", 32'(bus.out_count[4:0]), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 2) : 8'h77;
      chk($sformatf("wrap_rd%0d", i), 32'(bus.out_data[7:0]), 32'(exp_b));
      cycle(1'b0, 8'h00, 3'b001);
    end
    chk("wrap_empty", 32'(bus.out_valid[0]), 32'h0);

    // pop and commit in the same cycle on ch2, with gaps, then a len=0 packet
    pay.delete(); pay.push_back(8'h31);
    send_pkt(8'h06, 1'b0, 0, '0);
    chk("pc_count1", 32'(bus.out_count[14:10]), 32'd1);
    pay.delete(); pay.push_back(8'h41); pay.push_back(8'h42);
    send_pkt(8'h0A, 1'b0, 50, 3'b100);
    chk("pc_ok", 32'(bus.pkt_ok), 32'h1);
    chk("pc_count2", 32'(bus.out_count[14:10]), 32'd2);
    chk("pc_head", 32'(bus.out_data[23:16]), 32'h41);
    pay.delete();
    send_pkt(8'h02, 1'b0, 50, '0);
    chk("len0_ok", 32'(bus.pkt_ok), 32'h1);
    chk("len0_count", 32'(bus.out_count[14:10]), 32'd2);

    // reset in the middle of a packet
    cycle(1'b1, 8'h0D, '0);
    cycle(1'b1, 8'h11, '0);
    cycle(1'b1, 8'h22, '0);
    rst_n = 1'b0;
    cycle(1'b0, 8'h00, '0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_count", 32'(bus.out_count), 32'h0);
    rst_n = 1'b1;
    pay.delete(); pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    send_pkt(8'h0D, 1'b0, 0, '0);
    chk("mid_ok", 32'(bus.pkt_ok), 32'h1);
    chk("mid_count1", 32'(bus.out_count[9:5]), 32'd3);

    // random traffic against the model
    rand_rdy = 1'b1;
    for (int p = 0; p < 300; p++) begin
      ch  = int'($urandom_range(0, 3));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 5));
      hdr = {6'(len), 2'(ch)};
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
      send_pkt(hdr, ($urandom_range(0, 4) == 0), 30, '0);
    end
    rand_rdy = 1'b0;
    repeat (20) cycle(1'b0, 8'h00, 3'b111);
    chk("end_valid", 32'(bus.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_router_n.md
# pkt_router_n

Parametrised successor to the 3-channel byte router. Accepts framed packets (header, payload, parity) on a single byte stream and routes each payload to one of NCH output FIFOs. Adds whole-packet commit/rollback on parity failure, admission control on FIFO space, and drop reporting for invalid channels. Each output has a valid/ready read handshake. Sits between the input deserialiser and the per-channel consumers.

## Interface
- DW, default 8: data width; also the header width.
- NCH, default 3: number of output channels; 2..2**CHW.
- DEPTH, default 16: entries per channel FIFO; power of 2, ≥2.
- Derived: CHW = max(1, clog2(NCH)); LENW = DW−CHW; AW = clog2(DEPTH).
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  qualifies in_data. Gaps between bytes are allowed.
- in_data  in  DW  header, payload or parity byte.
- out_valid  out  NCH  channel c holds at least one committed byte.
- out_ready  in  NCH  consumer pop request for channel c.
- out_data  out  NCH*DW  head byte of channel c, in bits [c*DW +: DW]; 0 when the channel is empty.
- out_count  out  NCH*(AW+1)  committed occupancy of channel c.
- busy  out  1  high from the cycle after the header is accepted until the cycle after the parity byte.
- pkt_ok / pkt_err / pkt_drop  out  1 each  one-cycle end-of-packet status pulses.

## Operation
- Header byte fields: ch = hdr[CHW-1:0]; len = hdr[DW-1:CHW], range 0..2**LENW−1.
- Packet byte order: header, then len payload bytes, then one parity byte.
- Parity check passes when XOR(header, payload…) == parity byte.
- Input FSM states: IDLE, PAYLOAD, PARITY. Only cycles with in_valid=1 advance the FSM.
  - IDLE: a byte is a header. Latch ch, len, acc=hdr and payload counter=0. Go to PAYLOAD if len>0, else PARITY.
  - PAYLOAD: acc^=byte. If the packet is admitted, write the byte at the channel's speculative write pointer. After the len-th byte, go to PARITY.
  - PARITY: compare acc with the byte, pulse exactly one of ok/err/drop, return to IDLE.
- Admission is decided at the header cycle: drop = (ch ≥ NCH) or (len > DEPTH − out_count[ch]).
  - A dropped packet is still consumed fully. Nothing is written and parity is not evaluated.
  - pkt_drop pulses on the parity byte only. pkt_err never fires for a dropped packet.
- Each channel keeps a committed write pointer (wc), a speculative write pointer (ws), a read pointer (rp) and a count.
  - Payload writes advance ws only.
  - On a good parity byte, wc←ws and count+=len; pkt_ok pulses.
  - On a bad parity byte, ws←wc (rollback); count is unchanged; pkt_err pulses.
- Read side: a pop happens when out_ready[c] && out_valid[c]; rp++ and count−−. out_ready on an empty channel is ignored.
- A pop and a commit in the same cycle give count = count + len − 1.
- Reads only ever grow free space, so an admitted packet always fits.
- All pointers wrap modulo DEPTH. Count spans 0..DEPTH inclusive. A full channel (count=DEPTH) refuses every len≥1 packet; len=0 packets are still admitted.
- len=0 packet: header, then parity = header. pkt_ok pulses; no data is written and no count changes.
- Reset (synchronous rst_n low, including mid-packet):
  - FSM goes to IDLE; all pointers and counts go to 0; any partial packet is discarded.
  - out_valid=0, out_data=0, out_count=0, busy=0, and all pulses are 0.
  - FIFO storage contents are don't-care.

## Timing
- Header accepted at edge T: busy=1 from T+1.
- Parity byte at edge P: the pkt_* pulse, wc update and count update are all visible at P+1. busy=0 at P+1.
- out_valid and out_data change one cycle after a commit or pop edge.
- out_data is first-word-fall-through: it is registered FIFO state, combinationally muxed, with no read latency.
- Back-to-back packets: a header may arrive in the cycle right after the parity byte.
- Minimum packet duration is 2 cycles (len=0).
- No input backpressure: every in_valid byte is consumed.

## Test plan
- Good packet: ch1 header 0x0D (len 3), payload 0x11 0x22 0x33, parity 0x0D → pkt_ok at P+1; out_valid=3'b010; out_count[1]=3; popping yields 0x11, 0x22, 0x33, then out_valid[1]=0.
- Bad parity: same packet with parity 0x0C → pkt_err pulse; out_valid stays 0; a following good packet reads back only its own bytes (rollback verified).
- Invalid channel: header 0x07 (ch3, len 1), 0xAA, 0xAD → pkt_drop pulse, no pkt_err, no FIFO change.
- Full/wrap: send ch0 len 16 (0x40) with correct parity → count 16. Then header 0x04 + 1 byte + parity → pkt_drop. Pop 1, resend the same packet → pkt_ok, count 16, and data order is correct across the pointer wrap.
- Simultaneous pop and commit, with in_valid gaps and a len=0 packet (0x02, 0x02):
  - Hold out_ready[2]=1 while committing a len-2 ch2 packet onto count 1 → count 2.
  - The len=0 packet gives pkt_ok with count unchanged.
- Reset mid-packet: assert rst_n=0 after 2 payload bytes → next cycle busy=0, all out_valid=0, counts 0. After release, a fresh packet gives pkt_ok.
